// File: rtl/mem_if.sv
// Memory bus interface: decodes byte/half/word load/store commands, runs a req/ack
// handshake with timeout, and returns lane-extracted, sign/zero-extended read data.
module mem_if #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [1:0]        mem_size,
    input  logic              mem_unsigned,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              mdr_valid,
    output logic              mem_err,
    output logic              busy,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [31:0]       bus_wdata,
    input  logic              bus_ack,
    input  logic [31:0]       bus_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam logic [1:0] S_ERR  = 2'd3;

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       off_q;
    logic [1:0]       size_q;
    logic             uns_q;

    logic             cmd;
    logic             cmd_bad;
    logic [3:0]       be_next;
    logic [31:0]      wdata_next;
    logic [7:0]       lane_b;
    logic [15:0]      lane_h;
    logic [31:0]      load_ext;

    assign cmd  = mem_read | mem_write;
    assign busy = (state != S_IDLE);

    assign cmd_bad = (mem_read & mem_write)
                   | (mem_size == 2'b11)
                   | ((mem_size == 2'b01) & addr[0])
                   | ((mem_size == 2'b10) & (addr[1:0] != 2'b00));

    // NOTE: every output of a combinational block gets a default first, so no path
    // through the case leaves it unassigned and a latch cannot be inferred.
    always_comb begin
        be_next    = 4'b1111;
        wdata_next = wdata;
        case (mem_size)
            2'b00: begin
                be_next    = 4'b0001 << addr[1:0];
                wdata_next = {4{wdata[7:0]}};
            end
            2'b01: begin
                be_next    = addr[1] ? 4'b1100 : 4'b0011;
                wdata_next = {2{wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Lane selection uses the offset captured with the command, not the live addr.
    assign lane_b = bus_rdata[{off_q, 3'b000} +: 8];
    assign lane_h = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];

    always_comb begin
        load_ext = bus_rdata;
        case (size_q)
            2'b00:   load_ext = {{24{~uns_q & lane_b[7]}}, lane_b};
            2'b01:   load_ext = {{16{~uns_q & lane_h[15]}}, lane_h};
            default: ;
        endcase
    end

    // NOTE: state and outputs use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            off_q     <= 2'b00;
            size_q    <= 2'b00;
            uns_q     <= 1'b0;
            rdata     <= 32'h0;
            mdr_valid <= 1'b0;
            mem_err   <= 1'b0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_be    <= 4'b0000;
            bus_wdata <= 32'h0;
        end else begin
            mdr_valid <= 1'b0;
            mem_err   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd) begin
                        if (cmd_bad) begin
                            state   <= S_ERR;
                            mem_err <= 1'b1;
                        end else begin
                            state     <= S_REQ;
                            cnt       <= '0;
                            bus_req   <= 1'b1;
                            bus_we    <= mem_write;
                            bus_addr  <= {addr[ADDR_W-1:2], 2'b00};
                            bus_be    <= be_next;
                            bus_wdata <= wdata_next;
                            off_q     <= addr[1:0];
                            size_q    <= mem_size;
                            uns_q     <= mem_unsigned;
                        end
                    end
                end
                S_REQ: begin
                    // Ack is tested first so an ack on the last permitted cycle wins.
                    if (bus_ack) begin
                        state     <= S_RESP;
                        bus_req   <= 1'b0;
                        mdr_valid <= 1'b1;
                        if (!bus_we) rdata <= load_ext;
                    end else if (cnt == CNT_LAST) begin
                        state   <= S_ERR;
                        bus_req <= 1'b0;
                        mem_err <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_if.sv
// Randomized scoreboard bench for mem_if: driver predicts responses from a
// behavioural model, a separate monitor checks every mdr_valid / mem_err pulse.
module tb_mem_if;

    localparam int TO = 4;

    logic        clk;
    logic        rst;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_size;
    logic        mem_unsigned;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        mdr_valid;
    logic        mem_err;
    logic        busy;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    mem_if #(.ADDR_W(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size),
        .mem_unsigned(mem_unsigned), .addr(addr), .wdata(wdata),
        .rdata(rdata), .mdr_valid(mdr_valid), .mem_err(mem_err), .busy(busy),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          is_err;
        logic [31:0] rdata;
    } resp_t;

    resp_t       exp_q[$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] model_rdata = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic bit model_err(bit rd, bit wr, logic [1:0] sz, int off);
        return (rd && wr) || (sz == 2'd3) || (sz == 2'd1 && (off % 2) != 0)
            || (sz == 2'd2 && off != 0);
    endfunction

    function automatic logic [3:0] model_be(logic [1:0] sz, int off);
        case (sz)
            2'd0:    return 4'(1 << off);
            2'd1:    return 4'(3 << off);
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] model_wdata(logic [1:0] sz, logic [31:0] wd);
        case (sz)
            2'd0:    return (wd & 32'hFF) * 32'h0101_0101;
            2'd1:    return (wd & 32'hFFFF) * 32'h0001_0001;
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] model_load(logic [1:0] sz, bit uns, int off, logic [31:0] w);
        logic [31:0] v;
        case (sz)
            2'd0: begin
                v = (w >> (8 * off)) & 32'hFF;
                if (!uns && v >= 32'd128) v = v | 32'hFFFF_FF00;
            end
            2'd1: begin
                v = (w >> (16 * (off / 2))) & 32'hFFFF;
                if (!uns && v >= 32'd32768) v = v | 32'hFFFF_0000;
            end
            default: v = w;
        endcase
        return v;
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        resp_t r;
        if (mdr_valid || mem_err) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {30'b0, mdr_valid, mem_err}, 32'h0);
            end else begin
                r = exp_q.pop_front();
                check("pulse_err", {31'b0, mem_err}, {31'b0, r.is_err});
                check("pulse_valid", {31'b0, mdr_valid}, {31'b0, !r.is_err});
                check("rdata", rdata, r.rdata);
            end
        end
    end

    // ---------------- driver ----------------
    // ack_at: REQ cycle index (0-based) in which ack is given; <0 or >=TO means none.
    task automatic access(input bit rd, input bit wr, input logic [1:0] sz, input bit uns,
                          input logic [31:0] a, input logic [31:0] wd, input int ack_at,
                          input logic [31:0] word, input bit spurious);
        int    off;
        bit    e;
        bit    acked;
        int    n;
        resp_t r;
        off   = int'(a[1:0]);
        e     = model_err(rd, wr, sz, off);
        acked = (ack_at >= 0) && (ack_at < TO);
        @(negedge clk);
        mem_read     = rd;
        mem_write    = wr;
        mem_size     = sz;
        mem_unsigned = uns;
        addr         = a;
        wdata        = wd;
        if (e || !acked) begin
            r.is_err = 1'b1;
        end else begin
            r.is_err = 1'b0;
            if (rd) model_rdata = model_load(sz, uns, off, word);
        end
        r.rdata = model_rdata;
        exp_q.push_back(r);
        @(negedge clk);
        mem_read  = 1'b0;
        mem_write = 1'b0;
        check("busy_after_cmd", {31'b0, busy}, 32'h1);
        if (e) begin
            check("err_no_req", {31'b0, bus_req}, 32'h0);
        end else begin
            check("bus_we", {31'b0, bus_we}, {31'b0, wr});
            check("bus_addr", bus_addr, {a[31:2], 2'b00});
            check("bus_be", {28'b0, bus_be}, {28'b0, model_be(sz, off)});
            if (wr) check("bus_wdata", bus_wdata, model_wdata(sz, wd));
            n = 0;
            for (int i = 0; i < TO + 2; i++) begin
                if (!bus_req) break;
                n++;
                if (i > 0) check("be_held", {28'b0, bus_be}, {28'b0, model_be(sz, off)});
                if (spurious && i == 1) begin
                    mem_read = 1'b1;
                    addr     = a ^ 32'h0000_1001;
                end
                if (i == ack_at) begin
                    bus_ack   = 1'b1;
                    bus_rdata = word;
                end
                @(negedge clk);
                bus_ack   = 1'b0;
                mem_read  = 1'b0;
                addr      = a;
                bus_rdata = $urandom;
            end
            check("req_cycles", n, acked ? ack_at + 1 : TO);
        end
        @(negedge clk);
        check("idle_after", {30'b0, busy, bus_req}, 32'h0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; mem_size = 2'b00;
        mem_unsigned = 1'b0; addr = 32'h0; wdata = 32'h0; bus_ack = 1'b0;
        bus_rdata = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_outputs", {28'b0, busy, bus_req, mdr_valid, mem_err}, 32'h0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_bus", {bus_addr ^ bus_wdata, 28'b0}, 32'h0);
        check("rst_be_we", {27'b0, bus_we, bus_be}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases
        access(1, 0, 2'd2, 0, 32'h100, 32'h0, 3, 32'hDEAD_BEEF, 0);
        check("word_read", rdata, 32'hDEAD_BEEF);
        access(1, 0, 2'd0, 0, 32'h203, 32'h0, 0, 32'h80FF_0000, 0);
        check("byte_signed", rdata, 32'hFFFF_FF80);
        access(1, 0, 2'd0, 1, 32'h203, 32'h0, 1, 32'h80FF_0000, 0);
        check("byte_unsigned", rdata, 32'h0000_0080);
        access(0, 1, 2'd1, 0, 32'h302, 32'h1234_ABCD, 0, 32'h0, 0);
        check("write_keeps_rdata", rdata, 32'h0000_0080);
        access(1, 0, 2'd2, 0, 32'h101, 32'h0, 0, 32'h0, 0);
        access(1, 1, 2'd2, 0, 32'h100, 32'h0, 0, 32'h0, 0);
        access(1, 0, 2'd3, 0, 32'h100, 32'h0, 0, 32'h0, 0);
        access(1, 0, 2'd2, 0, 32'h400, 32'h0, -1, 32'h0, 0);
        access(1, 0, 2'd1, 0, 32'h402, 32'h0, TO - 1, 32'h8001_7FFF, 1);

        // Reset in the second REQ cycle with a stray command and a late ack
        @(negedge clk);
        mem_read = 1'b1; mem_size = 2'd2; addr = 32'h40;
        @(negedge clk);
        check("rst_case_req", {31'b0, bus_req}, 32'h1);
        addr = 32'h80;
        @(negedge clk);
        mem_read = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus_ack = 1'b1;
        bus_rdata = 32'h1111_2222;
        model_rdata = 32'h0;
        check("rst_abort", {30'b0, busy, bus_req}, 32'h0);
        check("rst_abort_rdata", rdata, 32'h0);
        @(negedge clk);
        bus_ack = 1'b0;
        check("ack_ignored", {30'b0, busy, bus_req}, 32'h0);
        access(1, 0, 2'd2, 0, 32'h40, 32'h0, 2, 32'hCAFE_F00D, 0);
        check("read_after_rst", rdata, 32'hCAFE_F00D);

        // Randomized traffic
        for (int t = 0; t < 60; t++) begin
            int          s, c, o;
            logic [1:0]  sz;
            bit          rd, wr;
            s  = $urandom_range(0, 9);
            sz = (s < 3) ? 2'd0 : (s < 6) ? 2'd1 : (s < 9) ? 2'd2 : 2'd3;
            if ($urandom_range(0, 3) == 0 || sz == 2'd0) o = $urandom_range(0, 3);
            else if (sz == 2'd1) o = 2 * $urandom_range(0, 1);
            else o = 0;
            c  = $urandom_range(0, 15);
            rd = (c < 8);
            wr = (c == 0) || (c >= 8);
            access(rd, wr, sz, 1'($urandom_range(0, 1)),
                   ({$urandom} & 32'hFFFF_FFFC) | 32'(o), $urandom,
                   $urandom_range(0, 6) - 1, $urandom, 1'($urandom_range(0, 1)));
        end

        repeat (4) @(negedge clk);
        check("queue_empty", exp_q.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_if.md
# mem_if

Memory interface unit between the multicycle control FSM's MAR/MDR datapath and the external memory bus. It accepts a single-cycle read or write command, generates byte enables and lane-replicated write data for RISC-V byte/half/word accesses, and runs a req/ack handshake with a timeout. Read data is lane-extracted and sign- or zero-extended. Completion is signalled with the one-cycle `mdr_valid` pulse that the control FSM waits on in FETCH_1 and in the load/store states.

## Interface
- `ADDR_W`, 32, byte address width.
- `TIMEOUT`, 255, maximum cycles `bus_req` stays high without `bus_ack` before error; must be ≥1.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `mem_read`  in  1  one-cycle read command from control.
- `mem_write`  in  1  one-cycle write command from control.
- `mem_size`  in  2  00 byte, 01 half, 10 word, 11 illegal.
- `mem_unsigned`  in  1  1 = zero-extend read data, 0 = sign-extend.
- `addr`  in  ADDR_W  byte address (MAR); sampled with the command.
- `wdata`  in  32  store data (MDR); sampled with the command.
- `rdata`  out  32  extended read result; registered.
- `mdr_valid`  out  1  one-cycle completion pulse for both read and write.
- `mem_err`  out  1  one-cycle pulse on misalign, illegal size, conflicting command or timeout.
- `busy`  out  1  high whenever state ≠ IDLE.
- `bus_req`  out  1  request, held until ack or timeout.
- `bus_we`  out  1  1 = write.
- `bus_addr`  out  ADDR_W  word-aligned address; bits [1:0] = 0.
- `bus_be`  out  4  byte enables.
- `bus_wdata`  out  32  lane-replicated write data.
- `bus_ack`  in  1  one-cycle acknowledge; `bus_rdata` valid in the same cycle.
- `bus_rdata`  in  32  read word.

## Operation
- States:
  - IDLE
  - REQ
  - RESP
  - ERR
- Reset:
  - state = IDLE.
  - All outputs 0, including `rdata` and all `bus_*` registers.
  - Timeout counter = 0.
- In IDLE, a command (`mem_read` or `mem_write`) is decoded:
  - Both commands high → ERR, no bus access.
  - `mem_size`=11 → ERR.
  - Misaligned access (half with `addr[0]`=1, word with `addr[1:0]`≠0) → ERR.
  - Otherwise → REQ. `bus_addr`, `bus_we`, `bus_be`, `bus_wdata`, lane offset, size and unsigned flag are registered.
- Byte enables and write data:
  - Byte: `bus_be` = 1 << addr[1:0]; `bus_wdata` = {4{wdata[7:0]}}.
  - Half: `bus_be` = addr[1] ? 1100 : 0011; `bus_wdata` = {2{wdata[15:0]}}.
  - Word: `bus_be` = 1111; `bus_wdata` = wdata.
- REQ:
  - `bus_req`=1; all `bus_*` outputs held stable.
  - Counter increments each cycle without ack.
  - `bus_ack`=1 → RESP. On a read, the selected lane is extended into `rdata` on this edge.
  - Counter reaches TIMEOUT-1 with no ack → ERR.
  - Ack on the final permitted cycle wins over timeout.
- RESP:
  - `mdr_valid`=1 for one cycle, then → IDLE.
  - Writes leave `rdata` unchanged.
- ERR:
  - `mem_err`=1 for one cycle, `bus_req`=0, `rdata` unchanged, then → IDLE.
  - `mdr_valid` is not asserted.
- Commands arriving while `busy`=1 are ignored, not queued.
- `bus_ack` outside REQ is ignored.
- Read extension:
  - The byte lane is picked by the offset; the half lane by offset[1].
  - Bit 7 or 15 is replicated unless `mem_unsigned`=1.
  - `mem_unsigned` is ignored for word reads.

## Timing
- Command sampled at edge T. `bus_req` is high from T+1.
- Ack at cycle T+1+k (k ≥ 0) → `mdr_valid` high in cycle T+2+k.
- Minimum command-to-`mdr_valid` latency is 2 cycles.
- `rdata` is valid in the same cycle as `mdr_valid` and holds until the next successful read.
- Errors detected in IDLE: `mem_err` is high in cycle T+1; `bus_req` is never raised.
- Timeout: `bus_req` is high for exactly TIMEOUT cycles, then `mem_err` is high in the next cycle with `bus_req`=0.
- A new command is accepted in the cycle after the `mdr_valid` or `mem_err` pulse, when state is IDLE.
- `rst` in any state:
  - After that edge, state = IDLE and `bus_req`=0.
  - No `mdr_valid` or `mem_err` pulse is produced for the aborted access.
  - A pending ack is discarded.
- `busy` is registered with the state and rises at T+1.

## Test plan
- Word read, addr 0x100, ack after 3 wait cycles, `bus_rdata`=0xDEADBEEF → `bus_be`=1111, `bus_addr`=0x100, `mdr_valid` at T+5, `rdata`=0xDEADBEEF.
- Signed byte read, addr 0x203, `bus_rdata`=0x80FF_0000 → `bus_be`=1000, `rdata`=0xFFFFFF80. Repeat with `mem_unsigned`=1 → `rdata`=0x00000080.
- Half write, addr 0x302, `wdata`=0x1234ABCD → `bus_we`=1, `bus_be`=1100, `bus_wdata`=0xABCDABCD, `mdr_valid` one cycle after ack, `rdata` unchanged.
- Misaligned word read, addr 0x101; separately `mem_read` and `mem_write` both high; separately `mem_size`=11 → `mem_err` at T+1, `bus_req` never high, no `mdr_valid`.
- TIMEOUT=4, no ack → `bus_req` high 4 cycles, then `mem_err` pulse. Repeat with ack in the 4th cycle → `mdr_valid`, no `mem_err`.
- `rst` asserted during the second REQ cycle, then ack → `bus_req`=0 next cycle, no pulses. A second `mem_read` issued during `busy` is ignored. A new read after reset completes normally.
